// File: rtl/ysyx_041461_mdu.sv
// Radix-2 iterative RV64M multiply/divide: N+1 edges to out_valid (N=XLEN, XLEN/2 for W ops), 1 edge for div special cases.
// Accepts only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module ysyx_041461_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int HW = XLEN / 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_op;
  logic                r_word;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_prod;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_dvsr;
  logic [XLEN-1:0]     r_result;

  // Request decode: effective width, signedness and magnitudes
  logic              w_word;
  logic              w_s1_signed;
  logic              w_s2_signed;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN-1:0]   w_dvd_sx;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  assign w_word      = in_word & ((in_op == 3'd0) | in_op[2]);
  assign w_s1_signed = (in_op == 3'd0) | (in_op == 3'd1) | (in_op == 3'd2) | (in_op == 3'd4) | (in_op == 3'd6);
  assign w_s2_signed = (in_op == 3'd0) | (in_op == 3'd1) | (in_op == 3'd4) | (in_op == 3'd6);
  assign w_op1 = w_word ? {{HW{w_s1_signed & in_src1[HW-1]}}, in_src1[HW-1:0]} : in_src1;
  assign w_op2 = w_word ? {{HW{w_s2_signed & in_src2[HW-1]}}, in_src2[HW-1:0]} : in_src2;
  assign w_neg1 = w_s1_signed & w_op1[XLEN-1];
  assign w_neg2 = w_s2_signed & w_op2[XLEN-1];
  assign w_mag1 = w_neg1 ? -w_op1 : w_op1;
  assign w_mag2 = w_neg2 ? -w_op2 : w_op2;
  assign w_dvd_sx = w_word ? {{HW{in_src1[HW-1]}}, in_src1[HW-1:0]} : in_src1;
  assign w_div0 = w_word ? (in_src2[HW-1:0] == '0) : (in_src2 == '0);
  assign w_ovf  = ((in_op == 3'd4) | (in_op == 3'd6)) &
                  (w_word ? ((in_src1[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) & (&in_src2[HW-1:0]))
                          : ((in_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_src2)));
  assign w_special = in_op[2] & (w_div0 | w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = in_op[1] ? w_dvd_sx : '1;
    else if (w_ovf) w_special_res = in_op[1] ? '0 : w_dvd_sx;
  end

  // One shift-add / restoring-subtract step per CALC cycle
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_final;

  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_ge       = ~w_diff[XLEN];
  assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
  assign w_prod_s   = r_neg_q ? -w_prod_nxt : w_prod_nxt;
  assign w_quo_s    = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_s    = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    w_raw = '0;
    case (r_op)
      3'd0:                w_raw = w_prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_raw = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_raw = w_quo_s;
      default:             w_raw = w_rem_s;
    endcase
    w_final = r_word ? {{HW{w_raw[HW-1]}}, w_raw[HW-1:0]} : w_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
        S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = (r_state == S_IDLE);
    out_valid  = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    out_result = r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_word   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_op     <= in_op;
      r_word   <= w_word;
      r_neg_q  <= w_neg1 ^ w_neg2;
      r_neg_r  <= w_neg1;
      r_prod   <= '0;
      r_mcand  <= {{XLEN{1'b0}}, w_mag1};
      r_mplier <= w_mag2;
      r_rem    <= '0;
      // W dividends are pre-shifted so HW iterations consume exactly their bits
      r_quo    <= w_word ? {w_mag1[HW-1:0], {HW{1'b0}}} : w_mag1;
      r_dvsr   <= w_mag2;
      if (w_special) begin
        r_cnt    <= '0;
        r_result <= w_special_res;
      end else begin
        r_cnt <= w_word ? CNT_W'(HW) : CNT_W'(XLEN);
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_op[2]) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end else begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (r_cnt == CNT_W'(1)) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_mdu.sv
// Randomized and directed bench for ysyx_041461_mdu against a plain-arithmetic RV64M model.
module tb_ysyx_041461_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  ysyx_041461_mdu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic [63:0] r;
    logic [31:0] r32;
    longint sa, sb;
    longint unsigned ua, ub;
    int sa32, sb32;
    int unsigned ua32, ub32;
    logic ew;
    ew  = w && (op == 3'd0 || op >= 3'd4);
    r   = '0;
    r32 = '0;
    pa  = {{64{a[63]}}, a};
    pb  = {{64{b[63]}}, b};
    sa = a; sb = b; ua = a; ub = b;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    case (op)
      3'd0: begin p = pa * pb; r = ew ? {{32{p[31]}}, p[31:0]} : p[63:0]; end
      3'd1: begin p = pa * pb; r = p[127:64]; end
      3'd2: begin p = pa * $signed({64'b0, b}); r = p[127:64]; end
      3'd3: begin p = $signed({64'b0, a}) * $signed({64'b0, b}); r = p[127:64]; end
      default: begin
        if (ew) begin
          if (op == 3'd4) begin
            if (sb32 == 0) r32 = '1;
            else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r32 = a[31:0];
            else r32 = sa32 / sb32;
          end else if (op == 3'd5) begin
            if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
          end else if (op == 3'd6) begin
            if (sb32 == 0) r32 = a[31:0];
            else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r32 = '0;
            else r32 = sa32 % sb32;
          end else begin
            if (ub32 == 0) r32 = a[31:0]; else r32 = ua32 % ub32;
          end
          r = {{32{r32[31]}}, r32};
        end else begin
          if (op == 3'd4) begin
            if (sb == 0) r = '1;
            else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = a;
            else r = sa / sb;
          end else if (op == 3'd5) begin
            if (ub == 0) r = '1; else r = ua / ub;
          end else if (op == 3'd6) begin
            if (sb == 0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = '0;
            else r = sa % sb;
          end else begin
            if (ub == 0) r = a; else r = ua % ub;
          end
        end
      end
    endcase
    return r;
  endfunction

  // Edges from accept to first out_valid, straight from the iteration count rules
  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic ew, zero, ovf;
    ew   = w && (op == 3'd0 || op >= 3'd4);
    zero = ew ? (b[31:0] == 0) : (b == 0);
    ovf  = (op == 3'd4 || op == 3'd6) &&
           (ew ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (op >= 3'd4 && (zero || ovf)) return 1;
    return ew ? 33 : 65;
  endfunction

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scribble the inputs while busy; the unit must ignore them
    in_op   = 3'($urandom_range(0, 7));
    in_word = 1'($urandom_range(0, 1));
    in_src1 = {$urandom, $urandom};
    in_src2 = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat);
    int e;
    issue(op, w, a, b);
    wait_valid(e);
    chk({tag, "_lat"}, 64'(e), 64'(lat));
    chk({tag, "_res"}, out_result, exp);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int e;
    int seen;
    logic [63:0] held;
    logic [2:0] op;
    logic w;
    logic [63:0] a, b;

    vecs[0]  = '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[2]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[6]  = '{3'd5, 1'b1, 64'hDEAD_0000_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33};
    vecs[7]  = '{3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[8]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[9]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[10] = '{3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 11; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat);

    // Backpressure: DONE must hold steady while out_ready is low
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 64'd123456789, 64'd987654321);
    wait_valid(e);
    chk("bp_lat", 64'(e), 64'd65);
    held = out_result;
    chk("bp_res", held, 64'd121932631112635269);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", out_result, 64'd121932631112635269);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Flush in the 20th CALC cycle; the op must never complete
    issue(3'd4, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    // Flush together with in_valid in IDLE must not accept
    in_op = 3'd5; in_word = 1'b0; in_src1 = 64'd9; in_src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_valid", 64'(out_valid), 64'd0);
    run("after_flush", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Reset mid-CALC
    issue(3'd1, 1'b0, 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_result", out_result, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = w ? {b[63:32], 32'd0} : 64'd0;
        1: begin
          b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
        end
        2: begin
          a = 64'($urandom_range(0, 300));
          b = 64'($urandom_range(1, 20));
        end
        3: b = {32'd0, b[31:0]} >> $urandom_range(0, 31);
        default: ;
      endcase
      run($sformatf("rnd%0d_op%0d_w%0d", i, op, w), op, w, a, b, ref_mdu(op, w, a, b), ref_lat(op, w, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
